rotor_stepper: RTL and testbench

ROTOR_STEPPER -- requirements
Module: rotor_stepper

---
 rtl/rotor_stepper.sv | 122 ++++++++++++
 tb/tb_rotor_stepper.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rotor_stepper.sv
// Rotor stepper: NUM_ROTORS chained modulo-MODULUS position counters that
// advance together on a key-press step, odometer style or with the Enigma
// pawl double-step when DOUBLE_STEP_EN is defined.
// Optional feature macro: DOUBLE_STEP_EN.

// Per-rotor datapath: increment with wrap, notch match, load range check.
module rotor_cell #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 26
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic [WIDTH-1:0] notch_val_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic [WIDTH-1:0] ld_fix_o,
  output logic             ld_bad_o,
  output logic             at_notch_o,
  output logic             at_top_o
);
  // One extra bit so MODULUS == 2**WIDTH compares correctly.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  assign at_top_o   = (cur_i == TOP);
  assign nxt_o      = at_top_o ? '0 : cur_i + WIDTH'(1);
  assign ld_bad_o   = ({1'b0, ld_val_i} >= MOD_W);
  assign ld_fix_o   = ld_bad_o ? '0 : ld_val_i;
  // An out-of-range notch can never match a legal position.
  assign at_notch_o = ({1'b0, notch_val_i} < MOD_W) && (cur_i == notch_val_i);
endmodule

module rotor_stepper #(
  parameter int NUM_ROTORS = 3,
  parameter int WIDTH      = 5,
  parameter int MODULUS    = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_ROTORS*WIDTH-1:0] load_pos,
  input  logic [NUM_ROTORS*WIDTH-1:0] notch_pos,
  input  logic                        step,
  output logic [NUM_ROTORS*WIDTH-1:0] pos,
  output logic                        step_done,
  output logic                        wrap_out,
  output logic                        err
);
  logic [NUM_ROTORS-1:0][WIDTH-1:0] pos_q, pos_d;
  logic [NUM_ROTORS-1:0][WIDTH-1:0] nxt, ld_fix;
  logic [NUM_ROTORS-1:0]            ld_bad, at_notch, at_top, adv;
  logic                             done_q, done_d;
  logic                             wrap_q, wrap_d;
  logic                             err_q, err_d;

  genvar g;
  generate
    for (g = 0; g < NUM_ROTORS; g++) begin : g_rotor
      rotor_cell #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_cell (
        .cur_i      (pos_q[g]),
        .ld_val_i   (load_pos[g*WIDTH +: WIDTH]),
        .notch_val_i(notch_pos[g*WIDTH +: WIDTH]),
        .nxt_o      (nxt[g]),
        .ld_fix_o   (ld_fix[g]),
        .ld_bad_o   (ld_bad[g]),
        .at_notch_o (at_notch[g]),
        .at_top_o   (at_top[g])
      );
    end
  endgenerate

  // Which rotors advance on a step; decided from pre-step positions only.
  always_comb begin
    adv    = '0;
    adv[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++) begin
`ifdef DOUBLE_STEP_EN
      // Pawl k rides on rotor k-1's notch, and also kicks rotor k along
      // when rotor k itself sits on its notch (leftmost has no such pawl).
      adv[k] = at_notch[k-1] | ((k <= NUM_ROTORS - 2) && at_notch[k]);
`else
      adv[k] = adv[k-1] & at_notch[k-1];
`endif
    end
  end

  // Next-state: load beats step; step also produces the done/wrap pulses.
  always_comb begin
    pos_d  = pos_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (load) begin
      pos_d = ld_fix;
      err_d = |ld_bad;
    end else if (step) begin
      for (int k = 0; k < NUM_ROTORS; k++)
        if (adv[k]) pos_d[k] = nxt[k];
      done_d = 1'b1;
      wrap_d = adv[NUM_ROTORS-1] & at_top[NUM_ROTORS-1];
    end
  end

  // State registers; reset discards any coincident load or step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign pos       = pos_q;
  assign step_done = done_q;
  assign wrap_out  = wrap_q;
  assign err       = err_q;
endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper (3 rotors, modulus 26). Expected outputs
// are queued when a cycle is driven and popped/compared one cycle later.
module tb_rotor_stepper;
  logic        clk = 1'b0;
  logic        rst, load, step;
  logic [14:0] load_pos, notch_pos;
  logic [14:0] pos;
  logic        step_done, wrap_out, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [14:0] pos;
    logic        done;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];

  rotor_stepper #(.NUM_ROTORS(3), .WIDTH(5), .MODULUS(26)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_pos (load_pos),
    .notch_pos(notch_pos),
    .step     (step),
    .pos      (pos),
    .step_done(step_done),
    .wrap_out (wrap_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input int a2, input int a1, input int a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic exp_t E(input string t, input int a2, input int a1, input int a0,
                             input logic d, input logic w, input logic e);
    exp_t x;
    x.tag = t; x.pos = pk(a2, a1, a0); x.done = d; x.wrap = w; x.err = e;
    return x;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty got none exp entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (pos === e.pos) else begin
      errors++;
      $error("FAIL %s pos got %h exp %h", e.tag, pos, e.pos);
    end
    checks++;
    assert (step_done === e.done) else begin
      errors++;
      $error("FAIL %s step_done got %b exp %b", e.tag, step_done, e.done);
    end
    checks++;
    assert (wrap_out === e.wrap) else begin
      errors++;
      $error("FAIL %s wrap_out got %b exp %b", e.tag, wrap_out, e.wrap);
    end
    checks++;
    assert (err === e.err) else begin
      errors++;
      $error("FAIL %s err got %b exp %b", e.tag, err, e.err);
    end
  endtask

  // Drive one cycle, queue its expected result, sample #1 after the edge.
  task automatic cyc(input logic r, input logic l, input logic s,
                     input logic [14:0] lp, input exp_t e);
    rst = r; load = l; step = s; load_pos = lp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  int r0, r1, r2;
  logic a1, a2;

  initial begin
    rst = 1'b1; load = 1'b0; step = 1'b0;
    load_pos = '0; notch_pos = pk(16, 4, 21);
    @(posedge clk);
    #1;

    cyc(1, 0, 0, '0, E("reset", 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, '0, E("idle_hold", 0, 0, 0, 0, 0, 0));

`ifdef DOUBLE_STEP_EN
    cyc(0, 1, 0, pk(0, 3, 20), E("ds_load", 0, 3, 20, 0, 0, 0));
    cyc(0, 0, 1, '0, E("ds_step1", 0, 3, 21, 1, 0, 0));
    cyc(0, 0, 1, '0, E("ds_step2", 0, 4, 22, 1, 0, 0));
    cyc(0, 0, 1, '0, E("ds_step3", 1, 5, 23, 1, 0, 0));
    cyc(0, 0, 0, '0, E("ds_idle", 1, 5, 23, 0, 0, 0));
`else
    cyc(0, 1, 0, pk(0, 4, 22), E("odo_load1", 0, 4, 22, 0, 0, 0));
    cyc(0, 0, 1, '0, E("odo_step1", 0, 4, 23, 1, 0, 0));
    cyc(0, 1, 0, pk(0, 3, 21), E("odo_load2", 0, 3, 21, 0, 0, 0));
    cyc(0, 0, 1, '0, E("odo_step2", 0, 4, 22, 1, 0, 0));
    cyc(0, 0, 0, '0, E("odo_idle", 0, 4, 22, 0, 0, 0));
`endif

    // Full wrap of every rotor.
    notch_pos = pk(25, 25, 25);
    cyc(0, 1, 0, pk(25, 25, 25), E("wrap_load", 25, 25, 25, 0, 0, 0));
    cyc(0, 0, 1, '0, E("wrap_step", 0, 0, 0, 1, 1, 0));
    cyc(0, 0, 0, '0, E("wrap_idle", 0, 0, 0, 0, 0, 0));
    notch_pos = pk(16, 4, 21);

    // Load beats step; out-of-range load clamps and sets sticky err.
    cyc(0, 1, 1, pk(1, 2, 3), E("load_vs_step", 1, 2, 3, 0, 0, 0));
    cyc(0, 1, 0, pk(0, 30, 0), E("oor_load", 0, 0, 0, 0, 0, 1));
    cyc(0, 0, 1, '0, E("err_sticky_step", 0, 0, 1, 1, 0, 1));
    cyc(0, 0, 0, '0, E("err_sticky_idle", 0, 0, 1, 0, 0, 1));
    cyc(0, 1, 0, pk(1, 2, 3), E("err_clear", 1, 2, 3, 0, 0, 0));
    cyc(0, 1, 0, pk(31, 2, 26), E("oor_two", 0, 2, 0, 0, 0, 1));

    // Reset wins over step and load and clears err.
    cyc(1, 0, 1, '0, E("rst_step_err", 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, pk(5, 6, 7), E("load_567", 5, 6, 7, 0, 0, 0));
    cyc(1, 0, 1, '0, E("rst_step", 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, '0, E("rst_after", 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, pk(9, 9, 9), E("load_999", 9, 9, 9, 0, 0, 0));
    cyc(1, 1, 0, pk(3, 3, 3), E("rst_load", 0, 0, 0, 0, 0, 0));

    // Step held high for 30 cycles, checked against a small model.
    r0 = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 30; i++) begin
`ifdef DOUBLE_STEP_EN
      a1 = (r0 == 21) || (r1 == 4);
      a2 = (r1 == 4);
`else
      a1 = (r0 == 21);
      a2 = a1 && (r1 == 4);
`endif
      r0 = (r0 + 1) % 26;
      if (a1) r1 = (r1 + 1) % 26;
      if (a2) r2 = (r2 + 1) % 26;
      cyc(0, 0, 1, '0, E("hold_step", r2, r1, r0, 1, 0, 0));
    end
    cyc(0, 0, 0, '0, E("hold_final", 0, 1, 4, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
